reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies the PLL lock through a synchroniser and a
// consecutive-high filter, holds all reset channels for HOLD_CYCLES, then
// releases them one by one, STAGE_GAP cycles apart. Lock loss or a software
// request re-arms the sequence; lock-loss events are counted (saturating).
module reset_sequencer #(
    parameter int CHANNELS    = 3,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                clk25,
    input  logic                rst_n,
    input  logic                lock,
    input  logic                sw_req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready,
    output logic [7:0]          relock_count
);

    // Shared counter width: large enough for the biggest parameter, plus one bit.
    localparam int MAX_FH = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int MAX_GC = (STAGE_GAP > CHANNELS) ? STAGE_GAP : CHANNELS;
    localparam int MAXP   = (MAX_FH > MAX_GC) ? MAX_FH : MAX_GC;
    localparam int CW     = $clog2(MAXP) + 1;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [CW-1:0]       filt_q, filt_d;
    logic                lock_ok_q, lock_ok_d;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CHANNELS-1:0] rst_q, rst_d;
    logic                ready_q, ready_d;
    logic [7:0]          relock_q, relock_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Synchroniser and lock filter: lock_ok is registered from the next filter value.
    always_comb begin
        sync1_d = lock;
        sync2_d = sync1_q;
        if (!sync2_q) begin
            filt_d = '0;
        end else if (filt_q == CW'(LOCK_FILTER)) begin
            filt_d = filt_q;
        end else begin
            filt_d = filt_q + CW'(1);
        end
        lock_ok_d = (filt_d == CW'(LOCK_FILTER));
    end

    // Sequencer next-state and registered outputs. Channels release strictly
    // from bit 0 upward, so the released set is always a run of low-order zeros
    // and clearing channel idx is a left shift of the reset vector.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        ready_d  = ready_q;
        relock_d = relock_q;
        case (state_q)
            WAIT_LOCK: begin
                rst_d   = '1;
                ready_d = 1'b0;
                if (lock_ok_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!sync2_q) begin
                    state_d  = WAIT_LOCK;
                    rst_d    = '1;
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    relock_d = sat_inc8(relock_q);
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    rst_d = rst_q << 1;
                    cnt_d = '0;
                    idx_d = CW'(1);
                    if (CHANNELS == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (!sync2_q) begin
                    state_d  = WAIT_LOCK;
                    rst_d    = '1;
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    relock_d = sat_inc8(relock_q);
                end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    rst_d = rst_q << 1;
                    cnt_d = '0;
                    idx_d = idx_q + CW'(1);
                    if (idx_q == CW'(CHANNELS - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!sync2_q) begin
                    state_d  = WAIT_LOCK;
                    rst_d    = '1;
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    relock_d = sat_inc8(relock_q);
                end else if (sw_req) begin
                    state_d = HOLD;
                    rst_d   = '1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                rst_d   = '1;
                ready_d = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Synchroniser and filter registers.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            filt_q    <= '0;
            lock_ok_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            filt_q    <= filt_d;
            lock_ok_q <= lock_ok_d;
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            relock_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            relock_q <= relock_d;
        end
    end

    assign rst_out      = rst_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: table of {inputs, expected outputs} rows applied
// in a loop, expectations queued with their due edge and checked by a monitor,
// plus hand-written sequences for async reset, saturation and CHANNELS=1.
module tb_reset_sequencer;

    logic       clk25 = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       sw_req;
    logic [2:0] rst_out;
    logic       ready;
    logic [7:0] relock_count;

    logic       lock1;
    logic       sw_req1;
    logic [0:0] rst_out1;
    logic       ready1;
    logic [7:0] relock_count1;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    typedef struct {
        logic       lock;
        logic       sw;
        int         adv;
        logic [2:0] rst;
        logic       rdy;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        int         edge_no;
        int         id;
        logic [2:0] rst;
        logic       rdy;
        logic [7:0] cnt;
    } exp_t;

    exp_t sbq[$];

    reset_sequencer dut (
        .clk25        (clk25),
        .rst_n        (rst_n),
        .lock         (lock),
        .sw_req       (sw_req),
        .rst_out      (rst_out),
        .ready        (ready),
        .relock_count (relock_count)
    );

    reset_sequencer #(
        .CHANNELS    (1),
        .LOCK_FILTER (4),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (8)
    ) dut1 (
        .clk25        (clk25),
        .rst_n        (rst_n),
        .lock         (lock1),
        .sw_req       (sw_req1),
        .rst_out      (rst_out1),
        .ready        (ready1),
        .relock_count (relock_count1)
    );

    always #5 clk25 = ~clk25;

    always @(posedge clk25) edge_n++;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at edge %0d: got %0h, expected %0h", name, id, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    function automatic vec_t mk(input logic l, input logic s, input int a,
                                input logic [2:0] r, input logic d, input logic [7:0] c);
        vec_t v;
        v.lock = l;
        v.sw   = s;
        v.adv  = a;
        v.rst  = r;
        v.rdy  = d;
        v.cnt  = c;
        return v;
    endfunction

    function automatic exp_t mk_exp(input int e, input int id, input logic [2:0] r,
                                    input logic d, input logic [7:0] c);
        exp_t x;
        x.edge_no = e;
        x.id      = id;
        x.rst     = r;
        x.rdy     = d;
        x.cnt     = c;
        return x;
    endfunction

    // Scoreboard monitor: compares each queued expectation on its due edge.
    exp_t cur;
    always @(posedge clk25) begin
        #2;
        while (sbq.size() > 0 && sbq[0].edge_no <= edge_n) begin
            cur = sbq.pop_front();
            if (cur.edge_no != edge_n) begin
                chk("sb_missed_edge", cur.id, 32'(edge_n), 32'(cur.edge_no));
            end else begin
                chk("sb_rst_out", cur.id, 32'(rst_out), 32'(cur.rst));
                chk("sb_ready", cur.id, 32'(ready), 32'(cur.rdy));
                chk("sb_relock_count", cur.id, 32'(relock_count), 32'(cur.cnt));
            end
        end
    end

    initial begin
        vec_t vt[$];
        int   base;

        // Power-up release schedule: lock driven at c gives E = c+2, release at E+21/29/37.
        vt.push_back(mk(1, 0, 22, 3'b111, 0, 0));
        vt.push_back(mk(1, 0,  1, 3'b110, 0, 0));
        vt.push_back(mk(1, 0,  7, 3'b110, 0, 0));
        vt.push_back(mk(1, 0,  1, 3'b100, 0, 0));
        vt.push_back(mk(1, 0,  7, 3'b100, 0, 0));
        vt.push_back(mk(1, 0,  1, 3'b000, 1, 0));
        vt.push_back(mk(1, 0,  5, 3'b000, 1, 0));
        // Lock loss in RUN: F = c+2, reaction at F+1.
        vt.push_back(mk(0, 0,  2, 3'b000, 1, 0));
        vt.push_back(mk(0, 0,  1, 3'b111, 0, 1));
        vt.push_back(mk(0, 0,  4, 3'b111, 0, 1));
        // Re-lock reruns the full sequence.
        vt.push_back(mk(1, 0, 22, 3'b111, 0, 1));
        vt.push_back(mk(1, 0,  1, 3'b110, 0, 1));
        vt.push_back(mk(1, 0,  8, 3'b100, 0, 1));
        vt.push_back(mk(1, 0,  8, 3'b000, 1, 1));
        vt.push_back(mk(1, 0,  3, 3'b000, 1, 1));
        // sw_req in RUN: re-asserted next edge, rst_out[0] falls 17 edges later.
        vt.push_back(mk(1, 1,  1, 3'b111, 0, 1));
        vt.push_back(mk(1, 0, 15, 3'b111, 0, 1));
        vt.push_back(mk(1, 0,  1, 3'b110, 0, 1));
        vt.push_back(mk(1, 0,  8, 3'b100, 0, 1));
        vt.push_back(mk(1, 0,  8, 3'b000, 1, 1));
        // sw_req again, then a pulse during HOLD that must not restart the hold.
        vt.push_back(mk(1, 1,  1, 3'b111, 0, 1));
        vt.push_back(mk(1, 0,  3, 3'b111, 0, 1));
        vt.push_back(mk(1, 1,  1, 3'b111, 0, 1));
        vt.push_back(mk(1, 0, 11, 3'b111, 0, 1));
        vt.push_back(mk(1, 0,  1, 3'b110, 0, 1));
        vt.push_back(mk(1, 0,  8, 3'b100, 0, 1));
        vt.push_back(mk(1, 0,  8, 3'b000, 1, 1));
        // Lock loss and sw_req in the same cycle: loss wins, stays in WAIT_LOCK.
        vt.push_back(mk(0, 0,  2, 3'b000, 1, 1));
        vt.push_back(mk(0, 1,  1, 3'b111, 0, 2));
        vt.push_back(mk(0, 0,  3, 3'b111, 0, 2));
        // Filter glitch: two lock_s-high cycles, one low, then high; filter restarts.
        vt.push_back(mk(1, 0,  2, 3'b111, 0, 2));
        vt.push_back(mk(0, 0,  1, 3'b111, 0, 2));
        vt.push_back(mk(1, 0, 22, 3'b111, 0, 2));
        vt.push_back(mk(1, 0,  1, 3'b110, 0, 2));
        // Loss during RELEASE after channel 0 released.
        vt.push_back(mk(0, 0,  2, 3'b110, 0, 2));
        vt.push_back(mk(0, 0,  1, 3'b111, 0, 3));
        // Re-lock into RELEASE ahead of the asynchronous reset.
        vt.push_back(mk(1, 0, 23, 3'b110, 0, 3));
        vt.push_back(mk(1, 0,  3, 3'b110, 0, 3));

        rst_n   = 1'b0;
        lock    = 1'b0;
        sw_req  = 1'b0;
        lock1   = 1'b0;
        sw_req1 = 1'b0;

        // Reset state.
        repeat (3) step();
        chk("reset_rst_out", 0, 32'(rst_out), 32'h7);
        chk("reset_ready", 0, 32'(ready), 32'h0);
        chk("reset_relock_count", 0, 32'(relock_count), 32'h0);
        chk("reset_rst_out1", 0, 32'(rst_out1), 32'h1);
        rst_n = 1'b1;
        step();

        // CHANNELS=1, HOLD_CYCLES=1: rst_out and ready change together at E+6.
        lock1 = 1'b1;
        repeat (7) step();
        chk("ch1_rst_before", 0, 32'(rst_out1), 32'h1);
        chk("ch1_ready_before", 0, 32'(ready1), 32'h0);
        step();
        chk("ch1_rst_release", 0, 32'(rst_out1), 32'h0);
        chk("ch1_ready_release", 0, 32'(ready1), 32'h1);

        // Table-driven vectors through the scoreboard.
        foreach (vt[i]) begin
            lock   = vt[i].lock;
            sw_req = vt[i].sw;
            sbq.push_back(mk_exp(edge_n + vt[i].adv, i, vt[i].rst, vt[i].rdy, vt[i].cnt));
            repeat (vt[i].adv) step();
        end
        sw_req = 1'b0;

        // Asynchronous reset mid-RELEASE, between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 0, 32'(rst_out), 32'h7);
        chk("async_ready", 0, 32'(ready), 32'h0);
        chk("async_relock_count", 0, 32'(relock_count), 32'h0);
        step();
        rst_n = 1'b1;

        // Release from reset with lock steady high needs a fresh synchroniser/filter pass.
        base = edge_n;
        sbq.push_back(mk_exp(base + 22, 100, 3'b111, 0, 0));
        sbq.push_back(mk_exp(base + 23, 101, 3'b110, 0, 0));
        repeat (23) step();

        // Saturation: 300 lock-loss events from HOLD.
        for (int k = 0; k < 300; k++) begin
            lock = 1'b1;
            repeat (8) step();
            lock = 1'b0;
            repeat (4) step();
        end
        chk("sat_relock_count", 0, 32'(relock_count), 32'hFF);
        chk("sat_rst_out", 0, 32'(rst_out), 32'h7);
        chk("sat_ready", 0, 32'(ready), 32'h0);

        repeat (2) step();
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            chk("sb_never_reached", cur.id, 32'(edge_n), 32'(cur.edge_no));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
